// File: rtl/acq_seq.sv
// Multi-line acquisition sequencer: paces PRE/SAMPLE/GAP segments, issues DAC gain updates and
// pulser triggers, and streams decimated ADC samples into RAM at densely packed addresses.
module acq_seq #(
  parameter int unsigned ADC_DATA_W     = 10,
  parameter int unsigned DAC_DATA_W     = 10,
  parameter int unsigned DAC_GAIN_N     = 32,
  parameter int unsigned DAC_GAIN_PTR_W = $clog2(DAC_GAIN_N),
  parameter int unsigned ACQ_LINES_MAX  = 32,
  parameter int unsigned LINE_CNT_W     = $clog2(ACQ_LINES_MAX),
  parameter int unsigned SEG_LEN_W      = 12,
  parameter int unsigned GAP_W          = 4,
  parameter int unsigned DECIM_W        = 4,
  parameter int unsigned RAM_DATA_W     = 16,
  parameter int unsigned RAM_ADDR_W     = 19,
  parameter int unsigned INICE_N        = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      acq_start,
  input  logic                      acq_abort,
  input  logic [LINE_CNT_W-1:0]     acq_lines,
  input  logic [SEG_LEN_W-1:0]      seg_len,
  input  logic [GAP_W-1:0]          gap_segs,
  input  logic [SEG_LEN_W-1:0]      gain_lead,
  input  logic [SEG_LEN_W-1:0]      trig_lead,
  input  logic [DECIM_W-1:0]        decim,
  input  logic [RAM_ADDR_W-1:0]     base_addr,
  input  logic [DAC_DATA_W-1:0]     dac_gain,
  input  logic [DAC_DATA_W-1:0]     dac_idle,
  input  logic [ADC_DATA_W-1:0]     adc_dout,
  input  logic [INICE_N-1:0]        inice,
  output logic [DAC_DATA_W-1:0]     dac_din,
  output logic                      dac_dvalid,
  output logic [DAC_GAIN_PTR_W-1:0] dac_gain_ptr,
  output logic                      pulser_trig,
  output logic                      acq_busy,
  output logic                      acq_done,
  output logic                      acq_aborted,
  output logic [LINE_CNT_W-1:0]     acq_line,
  output logic [RAM_ADDR_W-1:0]     acq_waddr,
  output logic [RAM_DATA_W-1:0]     acq_wdata,
  output logic                      acq_wen
);

  localparam logic [DAC_GAIN_PTR_W-1:0] SegLast = DAC_GAIN_PTR_W'(DAC_GAIN_N - 1);
  localparam logic [SEG_LEN_W-1:0]      SegOne  = SEG_LEN_W'(1);
  localparam int unsigned               TagW    = ADC_DATA_W + 2 + INICE_N;

  typedef enum logic [2:0] {StIdle, StPre, StSample, StGap, StDone} state_e;

  state_e state_q, state_d;

  // Latched run configuration; leads are stored as the wcnt value at which they fire.
  logic [SEG_LEN_W-1:0]  seg_last_q, seg_last_d;
  logic [SEG_LEN_W-1:0]  gain_at_q, gain_at_d;
  logic [SEG_LEN_W-1:0]  trig_at_q, trig_at_d;
  logic [GAP_W-1:0]      gap_last_q, gap_last_d;
  logic [DECIM_W-1:0]    decim_q, decim_d;
  logic [LINE_CNT_W-1:0] lines_q, lines_d;

  logic [SEG_LEN_W-1:0]      wcnt_q, wcnt_d;
  logic [DAC_GAIN_PTR_W-1:0] scnt_q, scnt_d;
  logic [GAP_W-1:0]          gcnt_q, gcnt_d;
  logic [DECIM_W-1:0]        dcnt_q, dcnt_d;
  logic [LINE_CNT_W-1:0]     line_q, line_d;
  logic [RAM_ADDR_W-1:0]     addr_q, addr_d;

  logic [DAC_DATA_W-1:0]     din_q, din_d;
  logic                      dvalid_q, dvalid_d;
  logic [DAC_GAIN_PTR_W-1:0] ptr_q, ptr_d;
  logic                      trig_q, trig_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      aborted_q, aborted_d;
  logic [RAM_ADDR_W-1:0]     waddr_q, waddr_d;
  logic [RAM_DATA_W-1:0]     wdata_q, wdata_d;
  logic                      wen_q, wen_d;

  logic active, start_ok, abort_hit, seg_end, gap_end_seg, lead_seg, samp_last_seg, line_end;
  logic gain_ev, trig_ev, idle_ev, write_ev;
  logic [RAM_DATA_W-1:0] wword;

  function automatic logic [SEG_LEN_W-1:0] lead_pos(input logic [SEG_LEN_W-1:0] len,
                                                    input logic [SEG_LEN_W-1:0] lead);
    if (lead >= len) return '0;
    return len - lead - SegOne;
  endfunction

  assign active        = (state_q == StPre) || (state_q == StSample) || (state_q == StGap);
  assign start_ok      = (state_q == StIdle) && acq_start;
  assign abort_hit     = active && acq_abort;
  assign seg_end       = (wcnt_q == seg_last_q);
  assign gap_end_seg   = (state_q == StGap) && (gcnt_q == gap_last_q);
  assign lead_seg      = (state_q == StPre) || gap_end_seg;
  assign samp_last_seg = (scnt_q == SegLast);
  assign line_end      = (state_q == StSample) && samp_last_seg && seg_end;

  assign gain_ev  = !abort_hit && (wcnt_q == gain_at_q) &&
                    (lead_seg || ((state_q == StSample) && !samp_last_seg));
  assign trig_ev  = !abort_hit && (wcnt_q == trig_at_q) && lead_seg;
  assign idle_ev  = !abort_hit && line_end;
  assign write_ev = !abort_hit && (state_q == StSample) && (dcnt_q == '0);

  always_comb begin
    wword = '0;
    wword[TagW-1:0] = {inice, line_q[1:0], adc_dout};
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (acq_start) state_d = StPre;
      StPre: begin
        if (acq_abort)    state_d = StDone;
        else if (seg_end) state_d = StSample;
      end
      StSample: begin
        if (acq_abort)     state_d = StDone;
        else if (line_end) state_d = (line_q == lines_q) ? StDone : StGap;
      end
      StGap: begin
        if (acq_abort)                    state_d = StDone;
        else if (seg_end && gap_end_seg) state_d = StSample;
      end
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM: registered outputs
  always_comb begin
    din_d     = din_q;
    dvalid_d  = 1'b0;
    ptr_d     = ptr_q;
    trig_d    = 1'b0;
    busy_d    = busy_q;
    done_d    = done_q;
    aborted_d = aborted_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wen_d     = 1'b0;
    if (start_ok) begin
      busy_d    = 1'b1;
      done_d    = 1'b0;
      aborted_d = 1'b0;
      ptr_d     = '0;
    end
    if (abort_hit) begin
      din_d     = dac_idle;
      dvalid_d  = 1'b1;
      aborted_d = 1'b1;
    end
    if (gain_ev) begin
      din_d    = dac_gain;
      dvalid_d = 1'b1;
      ptr_d    = (ptr_q == SegLast) ? '0 : ptr_q + DAC_GAIN_PTR_W'(1);
    end
    if (idle_ev) begin
      din_d    = dac_idle;
      dvalid_d = 1'b1;
    end
    if (trig_ev) trig_d = 1'b1;
    if (write_ev) begin
      wen_d   = 1'b1;
      waddr_d = addr_q;
      wdata_d = wword;
    end
    if (state_q == StDone) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
  end

  // Datapath counters and configuration capture
  always_comb begin
    seg_last_d = seg_last_q;
    gain_at_d  = gain_at_q;
    trig_at_d  = trig_at_q;
    gap_last_d = gap_last_q;
    decim_d    = decim_q;
    lines_d    = lines_q;
    wcnt_d     = (active && !seg_end) ? wcnt_q + SegOne : '0;
    scnt_d     = '0;
    gcnt_d     = '0;
    dcnt_d     = '0;
    line_d     = line_q;
    addr_d     = addr_q;
    if (start_ok) begin
      seg_last_d = seg_len - SegOne;
      gain_at_d  = lead_pos(seg_len, gain_lead);
      trig_at_d  = lead_pos(seg_len, trig_lead);
      gap_last_d = (gap_segs == '0) ? '0 : gap_segs - GAP_W'(1);
      decim_d    = decim;
      lines_d    = acq_lines;
      line_d     = '0;
      addr_d     = base_addr;
    end
    if (state_q == StSample) begin
      scnt_d = seg_end ? (samp_last_seg ? '0 : scnt_q + DAC_GAIN_PTR_W'(1)) : scnt_q;
      dcnt_d = (dcnt_q == decim_q) ? '0 : dcnt_q + DECIM_W'(1);
    end
    if (state_q == StGap) begin
      gcnt_d = seg_end ? gcnt_q + GAP_W'(1) : gcnt_q;
      if (seg_end && gap_end_seg && !acq_abort) line_d = line_q + LINE_CNT_W'(1);
    end
    if (write_ev) addr_d = addr_q + RAM_ADDR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_last_q <= '0;
      gain_at_q  <= '0;
      trig_at_q  <= '0;
      gap_last_q <= '0;
      decim_q    <= '0;
      lines_q    <= '0;
      wcnt_q     <= '0;
      scnt_q     <= '0;
      gcnt_q     <= '0;
      dcnt_q     <= '0;
      line_q     <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      dvalid_q   <= 1'b0;
      ptr_q      <= '0;
      trig_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wen_q      <= 1'b0;
    end else begin
      seg_last_q <= seg_last_d;
      gain_at_q  <= gain_at_d;
      trig_at_q  <= trig_at_d;
      gap_last_q <= gap_last_d;
      decim_q    <= decim_d;
      lines_q    <= lines_d;
      wcnt_q     <= wcnt_d;
      scnt_q     <= scnt_d;
      gcnt_q     <= gcnt_d;
      dcnt_q     <= dcnt_d;
      line_q     <= line_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      dvalid_q   <= dvalid_d;
      ptr_q      <= ptr_d;
      trig_q     <= trig_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wen_q      <= wen_d;
    end
  end

  assign dac_din      = din_q;
  assign dac_dvalid   = dvalid_q;
  assign dac_gain_ptr = ptr_q;
  assign pulser_trig  = trig_q;
  assign acq_busy     = busy_q;
  assign acq_done     = done_q;
  assign acq_aborted  = aborted_q;
  assign acq_line     = line_q;
  assign acq_waddr    = waddr_q;
  assign acq_wdata    = wdata_q;
  assign acq_wen      = wen_q;

endmodule

// File: tb/tb_acq_seq.sv
// Bench for acq_seq: table of run configurations with expected totals, plus a per-cycle
// reference model derived from the segment timeline arithmetic.
module tb_acq_seq;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        acq_start, acq_abort;
  logic [4:0]  acq_lines;
  logic [11:0] seg_len, gain_lead, trig_lead;
  logic [3:0]  gap_segs, decim;
  logic [18:0] base_addr;
  logic [9:0]  dac_gain, dac_idle, adc_dout;
  logic [2:0]  inice;
  logic [9:0]  dac_din;
  logic        dac_dvalid, pulser_trig, acq_busy, acq_done, acq_aborted, acq_wen;
  logic [1:0]  dac_gain_ptr;
  logic [4:0]  acq_line;
  logic [18:0] acq_waddr;
  logic [15:0] acq_wdata;

  logic [9:0] gain_tab [N];
  logic [9:0] adc_hist [512];
  logic [2:0] inice_hist [512];

  int checks = 0;
  int errors = 0;
  int vec_id = -1;

  always #5 clk = ~clk;
  assign dac_gain = gain_tab[dac_gain_ptr];

  acq_seq #(.DAC_GAIN_N(N)) dut (
    .clk(clk), .rst(rst), .acq_start(acq_start), .acq_abort(acq_abort),
    .acq_lines(acq_lines), .seg_len(seg_len), .gap_segs(gap_segs), .gain_lead(gain_lead),
    .trig_lead(trig_lead), .decim(decim), .base_addr(base_addr), .dac_gain(dac_gain),
    .dac_idle(dac_idle), .adc_dout(adc_dout), .inice(inice), .dac_din(dac_din),
    .dac_dvalid(dac_dvalid), .dac_gain_ptr(dac_gain_ptr), .pulser_trig(pulser_trig),
    .acq_busy(acq_busy), .acq_done(acq_done), .acq_aborted(acq_aborted), .acq_line(acq_line),
    .acq_waddr(acq_waddr), .acq_wdata(acq_wdata), .acq_wen(acq_wen)
  );

  typedef struct {
    int s, lines, gap, decim, base, gl, tl, abort_at;
    int e_wen, e_dv, e_tr, e_busy, e_fdv, e_ftr, e_fwen, e_last, e_ab;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got %0h expected %0h", name, vec_id, act, exp);
    end
  endtask

  // Timeline position of condition cycle c: kind 0=pre, 1=sample, 2=gap; q = segment in phase.
  function automatic void decode(input int c, input int s, input int g,
                                 output int kind, output int q, output int l, output int w);
    int seg, r;
    seg = c / s;
    w   = c % s;
    kind = 0; q = 0; l = 0;
    if (seg > 0) begin
      r = seg - 1;
      l = r / (N + g);
      q = r % (N + g);
      if (q < N) kind = 1;
      else begin kind = 2; q = q - N; end
    end
  endfunction

  task automatic scramble_cfg();
    seg_len   = 12'($urandom_range(2, 15));
    acq_lines = 5'($urandom);
    gap_segs  = 4'($urandom);
    gain_lead = 12'($urandom_range(0, 15));
    trig_lead = 12'($urandom_range(0, 15));
    decim     = 4'($urandom);
    base_addr = 19'($urandom);
  endtask

  task automatic run_vec(input vec_t v);
    int g, a, done_c, ga, ta, gcount, wcount, n_dv, n_tr, n_wen, busy_n;
    int f_dv, f_tr, f_wen, last_addr, c, kind, q, l, w;
    bit ab, lastseg, e_dv, e_tr, e_wen;
    logic [9:0]  e_din;
    logic [18:0] e_addr;
    logic [15:0] e_data;
    logic [1:0]  l2;
    g = (v.gap == 0) ? 1 : v.gap;
    a = v.s * (1 + N * (v.lines + 1) + g * v.lines);
    ab = (v.abort_at >= 0);
    done_c = ab ? v.abort_at + 1 : a;
    ga = (v.gl >= v.s) ? 0 : v.s - 1 - v.gl;
    ta = (v.tl >= v.s) ? 0 : v.s - 1 - v.tl;
    gcount = 0; wcount = 0; n_dv = 0; n_tr = 0; n_wen = 0; busy_n = 0;
    f_dv = -1; f_tr = -1; f_wen = -1; last_addr = -1;
    @(negedge clk);
    seg_len = 12'(v.s); acq_lines = 5'(v.lines); gap_segs = 4'(v.gap); decim = 4'(v.decim);
    base_addr = 19'(v.base); gain_lead = 12'(v.gl); trig_lead = 12'(v.tl);
    dac_idle = 10'($urandom);
    acq_start = 1'b1;
    @(posedge clk);
    for (int j = 0; j <= done_c + 1; j++) begin
      @(negedge clk);
      chk("busy", acq_busy, (j <= done_c) ? 1 : 0);
      if (acq_busy) busy_n++;
      if (j == 0) begin
        chk("done_clr", acq_done, 0);
        chk("abort_clr", acq_aborted, 0);
      end
      if (j == done_c + 1) begin
        chk("done_end", acq_done, 1);
        chk("aborted_end", acq_aborted, ab ? 1 : 0);
      end
      e_dv = 0; e_tr = 0; e_wen = 0; e_din = '0; e_addr = '0; e_data = '0;
      if (j >= 1) begin
        c = j - 1;
        if (ab && c == v.abort_at) begin
          e_dv = 1; e_din = dac_idle;
        end else if (c < (ab ? v.abort_at : a)) begin
          decode(c, v.s, g, kind, q, l, w);
          lastseg = (kind == 0) || (kind == 2 && q == g - 1);
          if (w == ga && (lastseg || (kind == 1 && q < N - 1))) begin
            e_dv = 1; e_din = gain_tab[gcount % N]; gcount++;
          end
          if (kind == 1 && q == N - 1 && w == v.s - 1) begin
            e_dv = 1; e_din = dac_idle;
          end
          if (w == ta && lastseg) e_tr = 1;
          if (kind == 1 && ((q * v.s + w) % (v.decim + 1)) == 0) begin
            l2 = 2'(l);
            e_wen = 1;
            e_addr = 19'(v.base + wcount);
            e_data = {1'b0, inice_hist[c], l2, adc_hist[c]};
            wcount++;
          end
        end
      end
      chk("dvalid", dac_dvalid, e_dv);
      if (e_dv) chk("dac_din", dac_din, e_din);
      chk("trig", pulser_trig, e_tr);
      chk("wen", acq_wen, e_wen);
      if (e_wen) begin
        chk("waddr", acq_waddr, e_addr);
        chk("wdata", acq_wdata, e_data);
      end
      chk("gain_ptr", dac_gain_ptr, gcount % N);
      if (j < done_c) begin
        decode(j, v.s, g, kind, q, l, w);
        chk("line", acq_line, l);
      end
      if (dac_dvalid) begin n_dv++; if (f_dv < 0) f_dv = j; end
      if (pulser_trig) begin n_tr++; if (f_tr < 0) f_tr = j; end
      if (acq_wen) begin n_wen++; last_addr = int'(acq_waddr); if (f_wen < 0) f_wen = j; end
      adc_hist[j]   = 10'($urandom);
      inice_hist[j] = 3'($urandom);
      adc_dout  = adc_hist[j];
      inice     = inice_hist[j];
      acq_abort = (j == v.abort_at);
      acq_start = (j < done_c) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (j < done_c) scramble_cfg();
    end
    acq_abort = 1'b0;
    acq_start = 1'b0;
    chk("tot_writes", n_wen, v.e_wen);
    chk("tot_dvalid", n_dv, v.e_dv);
    chk("tot_trig", n_tr, v.e_tr);
    chk("busy_cycles", busy_n, v.e_busy);
    chk("first_dvalid", f_dv, v.e_fdv);
    chk("first_trig", f_tr, v.e_ftr);
    chk("first_wen", f_wen, v.e_fwen);
    chk("last_waddr", last_addr, v.e_last);
  endtask

  initial begin
    //          s lines gap dec base    gl  tl abort  wen dv tr busy fdv ftr fwen last     ab
    vecs[0] = '{8, 1, 1, 0, 'h100,   2,  0, -1,   64, 10, 2, 81, 6,  8,  9, 'h13F,   0};
    vecs[1] = '{8, 0, 1, 2, 'h200,   0,  0, -1,   11, 5,  1, 41, 8,  8,  9, 'h20A,   0};
    vecs[2] = '{8, 0, 1, 0, 'h7FFF0, 1,  3, -1,   32, 5,  1, 41, 7,  5,  9, 'hF,     0};
    vecs[3] = '{8, 0, 2, 0, 'h0,     20, 9, -1,   32, 5,  1, 41, 1,  1,  9, 'h1F,    0};
    vecs[4] = '{4, 2, 0, 1, 'h10,    1,  2, -1,   24, 15, 3, 61, 3,  2,  5, 'h27,    0};
    vecs[5] = '{6, 1, 3, 3, 'h40,    5,  5, -1,   12, 10, 2, 73, 1,  1,  7, 'h4B,    0};
    vecs[6] = '{2, 0, 1, 0, 'h300,   0,  1, -1,   8,  5,  1, 11, 2,  1,  3, 'h307,   0};
    vecs[7] = '{8, 1, 1, 0, 'h100,   2,  0, 18,   10, 3,  1, 20, 6,  8,  9, 'h109,   1};
    vecs[8] = '{4, 2, 2, 0, 'h7FFFE, 0,  3, 25,   16, 6,  2, 27, 4,  1,  5, 'hD,     1};
    vecs[9] = '{8, 0, 1, 0, 'h55,    2,  0, 3,    0,  1,  0, 5,  4,  -1, -1, -1,     1};
    for (int i = 0; i < N; i++) gain_tab[i] = 10'($urandom);
    rst = 1'b1; acq_start = 1'b0; acq_abort = 1'b0; adc_dout = '0; inice = '0;
    dac_idle = 10'($urandom);
    scramble_cfg();
    repeat (2) @(negedge clk);
    chk("rst_din", dac_din, 0);
    chk("rst_dvalid", dac_dvalid, 0);
    chk("rst_ptr", dac_gain_ptr, 0);
    chk("rst_trig", pulser_trig, 0);
    chk("rst_busy", acq_busy, 0);
    chk("rst_done", acq_done, 0);
    chk("rst_aborted", acq_aborted, 0);
    chk("rst_line", acq_line, 0);
    chk("rst_waddr", acq_waddr, 0);
    chk("rst_wdata", acq_wdata, 0);
    chk("rst_wen", acq_wen, 0);
    rst = 1'b0;
    // abort while idle must be ignored
    acq_abort = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_abort_busy", acq_busy, 0);
    chk("idle_abort_flag", acq_aborted, 0);
    chk("idle_abort_done", acq_done, 0);
    acq_abort = 1'b0;

    for (int i = 0; i < 10; i++) begin
      vec_id = i;
      run_vec(vecs[i]);
    end

    vec_id = 100;
    repeat (4) @(negedge clk);
    chk("done_held", acq_done, 1);
    chk("aborted_held", acq_aborted, 1);

    // asynchronous reset in the middle of a run
    vec_id = 101;
    seg_len = 12'd8; acq_lines = 5'd1; gap_segs = 4'd1; decim = 4'd0;
    base_addr = 19'h123; gain_lead = 12'd2; trig_lead = 12'd0;
    acq_start = 1'b1;
    @(negedge clk);
    acq_start = 1'b0;
    repeat (20) @(negedge clk);
    chk("busy_before_rst", acq_busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", acq_busy, 0);
    chk("arst_waddr", acq_waddr, 0);
    chk("arst_wdata", acq_wdata, 0);
    chk("arst_ptr", dac_gain_ptr, 0);
    chk("arst_din", dac_din, 0);
    chk("arst_line", acq_line, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", acq_busy, 0);
    chk("post_rst_done", acq_done, 0);
    vec_id = 2;
    run_vec(vecs[2]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/acq_seq.md
# acq_seq

Parametrised successor to the line-acquisition sequencer. It runs a multi-line ultrasound acquisition with runtime-configurable segment length, inter-line gap, gain/trigger lead times, sample decimation and a dense RAM start address. It sits between the CSR block, which supplies configuration, and three consumers: the DAC SPI driver (dac_din/dac_dvalid), the separate pulser engine (pulser_trig) and the external RAM writer (acq_waddr/wdata/wen). Supports abort mid-acquisition.

## Interface
- ADC_DATA_W, 10, ADC sample width
- DAC_DATA_W, 10, DAC code width
- DAC_GAIN_N, 32, gain segments per line (≥2)
- DAC_GAIN_PTR_W, $clog2(DAC_GAIN_N), gain pointer width
- ACQ_LINES_MAX, 32, max lines; LINE_CNT_W = $clog2(ACQ_LINES_MAX)
- SEG_LEN_W, 12, width of segment length and lead fields
- GAP_W, 4, width of gap segment count
- DECIM_W, 4, width of decimation field
- RAM_DATA_W, 16, RAM word width (≥ ADC_DATA_W+2+INICE_N)
- RAM_ADDR_W, 19, RAM address width
- INICE_N, 3, number of INICE inputs

- clk  in  1  system clock; reset rst, asynchronous, active-high; clock clk
- rst  in  1  asynchronous active-high reset
- acq_start  in  1  start request, sampled only in IDLE
- acq_abort  in  1  abort request, sampled in any non-IDLE state
- acq_lines  in  LINE_CNT_W  number of lines minus 1
- seg_len  in  SEG_LEN_W  clocks per segment (≥2)
- gap_segs  in  GAP_W  gap length between lines, in segments (0 treated as 1)
- gain_lead  in  SEG_LEN_W  clocks before segment end to issue gain update
- trig_lead  in  SEG_LEN_W  clocks before segment end to issue pulser trigger
- decim  in  DECIM_W  keep 1 of every decim+1 samples
- base_addr  in  RAM_ADDR_W  first write address
- dac_gain  in  DAC_DATA_W  gain code selected by dac_gain_ptr
- dac_idle  in  DAC_DATA_W  idle DAC code
- adc_dout  in  ADC_DATA_W  ADC sample
- inice  in  INICE_N  auxiliary tag inputs
- dac_din  out  DAC_DATA_W  DAC code
- dac_dvalid  out  1  one-cycle DAC load strobe
- dac_gain_ptr  out  DAC_GAIN_PTR_W  gain table index
- pulser_trig  out  1  one-cycle pulser start
- acq_busy  out  1  acquisition running
- acq_done  out  1  completed flag, held until the next accepted start
- acq_aborted  out  1  last run ended by abort, held until the next accepted start
- acq_line  out  LINE_CNT_W  current line index
- acq_waddr  out  RAM_ADDR_W  write address
- acq_wdata  out  RAM_DATA_W  write data
- acq_wen  out  1  write strobe

## Operation
- All configuration is latched on start acceptance; changes mid-run are ignored. Leads ≥ seg_len are clamped to seg_len-1.
- FSM states: IDLE, PRE, SAMPLE, GAP, DONE.
- Counters: wcnt (0..seg_len-1), scnt (0..DAC_GAIN_N-1), gcnt (gap segments), line, dcnt (decimation), addr.
- IDLE→PRE on acq_start. Side effects: acq_busy=1, acq_done=0, acq_aborted=0, dac_gain_ptr=0, addr=base_addr, line=0.
- PRE: one segment long, then →SAMPLE.
- SAMPLE: DAC_GAIN_N segments. At the last word:
  - dac_din=dac_idle with a dvalid pulse;
  - if line==acq_lines →DONE, else →GAP.
- GAP: max(gap_segs,1) segments. At its end, line+1 and →SAMPLE.
- Gain update, issued at wcnt==seg_len-1-gain_lead:
  - in the last segment of PRE/GAP;
  - in SAMPLE segments 0..N-2.
  - Action: dac_din=dac_gain, dac_dvalid=1, then dac_gain_ptr+1, wrapping N-1→0.
- Trigger: pulser_trig=1 at wcnt==seg_len-1-trig_lead in the last segment of PRE/GAP.
- Gain update and trigger may coincide in the same cycle; both are issued.
- Writes: in SAMPLE, a word is kept when dcnt==0. dcnt counts 0..decim, wraps, and resets to 0 at the start of each line.
  - acq_wdata = {zeros, inice, line[1:0], adc_dout}.
  - acq_waddr = addr; addr then increments, wrapping modulo 2^RAM_ADDR_W.
  - Addresses are densely packed across lines, with no per-line alignment.
- Abort in PRE/SAMPLE/GAP: next state DONE. That cycle issues an idle DAC pulse, no write and no trigger; acq_aborted=1.
- DONE: acq_busy=0, acq_done=1, →IDLE.
- acq_start while busy is ignored. Abort in IDLE or DONE is ignored.

## Timing
- Reset value of every output is 0.
- All outputs are registered. dac_din, dac_dvalid, pulser_trig, acq_waddr, acq_wdata and acq_wen appear one clk after the condition cycle.
- acq_wdata captures the adc_dout present in the SAMPLE cycle.
- acq_busy rises 1 clk after start acceptance. PRE wcnt=0 is that first busy cycle.
- acq_busy falls, and acq_done rises, in the same clk, one cycle after the last SAMPLE word (or the abort cycle).
- Busy cycles for a full run = seg_len·(1 + N·(L+1) + G·L) + 1, where L=acq_lines and G=max(gap_segs,1).
- Asynchronous reset mid-run returns to IDLE immediately with all outputs 0.

## Test plan
- N=4, seg_len=8, acq_lines=1, gap_segs=1, decim=0, base=0x100, start -> 64 writes at 0x100..0x13F; 10 dvalid (8 gain, 2 idle); 2 pulser_trig; busy 81 clks; done=1.
- Same setup, gain_lead=2, trig_lead=0 -> first gain dvalid 6 clks after busy rises (ptr 0→1); first trig 8 clks after busy rises; first wen 9 clks after busy rises.
- decim=2, seg_len=8, N=4, one line -> 11 writes (samples 0,3,…,30); addr base..base+10.
- base=0x7FFF0 (RAM_ADDR_W=19), 32 writes -> waddr wraps 0x7FFFF→0x00000 and ends at 0x0000F.
- Abort asserted at SAMPLE line 0, word 10 -> no wen after that word; one idle dvalid; acq_done=acq_aborted=1; busy low 2 clks after abort.
- gain_lead=20 with seg_len=8 -> behaves as gain_lead=7 (gain dvalid at wcnt 0); start asserted while busy -> ignored.
